// File: rtl/riscv_lsu_pipelined.sv
// Pipelined load/store unit: program-ordered completion queue between EXU and WBU
// with a Wishbone B4 pipelined master that keeps several bus cycles outstanding.
module riscv_lsu_pipelined #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [29:0] pc_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_width_i,
    input  logic [31:0] mem_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [29:0] pc_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_addr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] hz_pending_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] CODE_LD_MISAL = 2'd0;
    localparam logic [1:0] CODE_ST_MISAL = 2'd1;
    localparam logic [1:0] CODE_LD_BERR  = 2'd2;
    localparam logic [1:0] CODE_ST_BERR  = 2'd3;

    function automatic logic f_misaligned(input logic [2:0] w, input logic [1:0] a);
        case (w[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] f_sel(input logic [2:0] w, input logic [1:0] off);
        case (w[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the byte/half into every lane lets the slave pick it up from any lane.
    function automatic logic [31:0] f_wdata(input logic [2:0] w, input logic [31:0] d);
        case (w[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] w, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (w[1:0])
            2'b00:   return w[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return w[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return d;
        endcase
    endfunction

    logic [29:0]   r_pc    [DEPTH];
    logic [4:0]    r_rd    [DEPTH];
    logic          r_we    [DEPTH];
    logic [2:0]    r_wid   [DEPTH];
    logic [1:0]    r_off   [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic          r_done  [DEPTH];
    logic          r_fault [DEPTH];
    logic [1:0]    r_code  [DEPTH];
    logic [PW-1:0] r_bidx  [DEPTH];

    logic [PW-1:0] r_head, r_tail, r_bwr, r_brd;
    logic [CW-1:0] r_count, r_outst;
    logic          r_stb, r_cyc, r_bwe;
    logic [29:0]   r_addr;
    logic [3:0]    r_sel;
    logic [31:0]   r_wdata;

    logic          w_push, w_pop, w_stb_acc, w_rsp, w_misal, w_bus_req, w_stb_nxt;
    logic [CW-1:0] w_outst_nxt;
    logic [PW-1:0] w_rsp_idx, w_rel;
    logic [31:0]   w_hz;

    assign ready_o     = (r_count < FULL) && !(r_stb && wb_stall_i);
    assign w_push      = valid_i && ready_o;
    assign w_pop       = valid_o && ready_i;
    assign w_stb_acc   = r_stb && !wb_stall_i;
    assign w_rsp       = r_cyc && (wb_ack_i || wb_err_i);
    assign w_misal     = mem_valid_i && f_misaligned(mem_width_i, rd_data_i[1:0]);
    assign w_bus_req   = w_push && mem_valid_i && !w_misal;
    assign w_stb_nxt   = w_bus_req || (r_stb && wb_stall_i);
    assign w_outst_nxt = r_outst + CW'(w_stb_acc) - CW'(w_rsp);
    assign w_rsp_idx   = r_bidx[r_brd];

    // Every occupied entry plus the incoming op (stores have no destination).
    always_comb begin
        w_hz  = '0;
        w_rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel = PW'(i) - r_head;
            if ({1'b0, w_rel} < r_count)
                w_hz[r_rd[i]] = 1'b1;
        end
        if (valid_i && !(mem_valid_i && mem_we_i))
            w_hz[rd_addr_i] = 1'b1;
        w_hz[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_bwr   <= '0;
            r_brd   <= '0;
            r_count <= '0;
            r_outst <= '0;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_bwe   <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_rd[i]    <= '0;
                r_we[i]    <= 1'b0;
                r_wid[i]   <= '0;
                r_off[i]   <= '0;
                r_data[i]  <= '0;
                r_done[i]  <= 1'b0;
                r_fault[i] <= 1'b0;
                r_code[i]  <= '0;
                r_bidx[i]  <= '0;
            end
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_outst <= w_outst_nxt;
            r_stb   <= w_stb_nxt;
            r_cyc   <= w_stb_nxt || (w_outst_nxt != '0);

            // Clearing done on pop keeps a recycled slot from looking complete.
            if (w_pop) begin
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + PW'(1);
            end

            if (w_push) begin
                r_tail          <= r_tail + PW'(1);
                r_pc[r_tail]    <= pc_i;
                r_rd[r_tail]    <= (mem_valid_i && mem_we_i) ? 5'd0 : rd_addr_i;
                r_we[r_tail]    <= mem_valid_i && mem_we_i;
                r_wid[r_tail]   <= mem_width_i;
                r_off[r_tail]   <= rd_data_i[1:0];
                r_data[r_tail]  <= mem_valid_i ? 32'd0 : rd_data_i;
                r_done[r_tail]  <= !w_bus_req;
                r_fault[r_tail] <= w_misal;
                r_code[r_tail]  <= (w_misal && mem_we_i) ? CODE_ST_MISAL : CODE_LD_MISAL;
            end

            if (w_bus_req) begin
                r_bidx[r_bwr] <= r_tail;
                r_bwr         <= r_bwr + PW'(1);
                r_addr        <= rd_data_i[31:2];
                r_sel         <= f_sel(mem_width_i, rd_data_i[1:0]);
                r_wdata       <= f_wdata(mem_width_i, mem_data_i);
                r_bwe         <= mem_we_i;
            end

            // Responses arrive in strobe order, so the oldest bus entry is completed.
            if (w_rsp) begin
                r_brd             <= r_brd + PW'(1);
                r_done[w_rsp_idx] <= 1'b1;
                if (wb_err_i) begin
                    r_fault[w_rsp_idx] <= 1'b1;
                    r_code[w_rsp_idx]  <= r_we[w_rsp_idx] ? CODE_ST_BERR : CODE_LD_BERR;
                    r_data[w_rsp_idx]  <= 32'd0;
                end else begin
                    r_data[w_rsp_idx]  <= r_we[w_rsp_idx] ? 32'd0
                                          : f_load(r_wid[w_rsp_idx], r_off[w_rsp_idx], wb_data_i);
                end
            end
        end
    end

    assign valid_o      = r_done[r_head];
    assign pc_o         = r_pc[r_head];
    assign rd_addr_o    = r_rd[r_head];
    assign rd_data_o    = r_data[r_head];
    assign fault_o      = r_fault[r_head];
    assign fault_code_o = r_code[r_head];

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_bwe;
    assign wb_addr_o    = r_addr;
    assign wb_sel_o     = r_sel;
    assign wb_data_o    = r_wdata;
    assign hz_pending_o = w_hz;

endmodule
